if_fetch_stage: RTL

- Instruction-fetch front end of the 5-stage RISC-V pipeline.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the stall controls produced by hazard detection (`PCwrite`, `IF_IDwrite`) and the branch redirect from EX.
- Holds a fetched instruction while stalled, inserts NOP bubbles on flush, and discards in-flight fetches after a redirect.

---
 rtl/if_fetch_stage.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage - instruction-fetch front end of the 5-stage RISC-V pipeline.
//
// Owns the PC, the single-outstanding instruction-memory handshake and the
// IF/ID pipeline register. A fetched word is parked in a one-entry buffer
// while IF/ID is stalled. A branch redirect from EX loads a bubble and
// retargets the PC. A fetch still in flight at the redirect is dropped when
// it returns.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   PCwrite           0 freezes the PC            (hazard detection)
//   IF_IDwrite        0 freezes IF/ID             (hazard detection)
//   PCSrc             redirect request from EX; has priority over stalls
//   branch_target     redirect address, bits [1:0] forced to 0
//   imem_req/addr     level fetch request; address is stable while req=1
//   imem_valid/rdata  one-cycle response that completes the request
//   IF_ID_pc/instr/valid  IF/ID register contents (valid=0 marks a bubble)
//
// Optional feature (macro FETCH_STALL_CNT_EN):
//   stall_cycles      saturating count of cycles with advance=0 and PCSrc=0
//   flush_count       saturating count of cycles with PCSrc=1
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  // FETCH: request outstanding; HOLD: response parked, no request;
  // KILL: outstanding response will be discarded.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_KILL  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        advance_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  // Mismatched stall inputs count as a stall; redirect target is word aligned.
  always_comb begin
    advance_s = PCwrite & IF_IDwrite;
    target_s  = branch_target & 32'hFFFF_FFFC;
    pc_inc_s  = pc_q + 32'd4;
  end

  // Next-state logic: redirect first, then response/buffer handling.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      ST_FETCH: begin
        if (PCSrc) begin
          pc_d         = target_s;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          // With nothing in flight (first cycle after reset) or the response
          // arriving now, the target can be requested straight away.
          if (imem_valid || !req_q) begin
            addr_d  = target_s;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_KILL;
          end
        end else if (imem_valid) begin
          if (advance_s) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc_s;
            addr_d       = pc_inc_s;
          end else begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (IF_IDwrite) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else begin
          ifid_valid_d = ifid_valid_q;
        end
      end

      ST_HOLD: begin
        if (PCSrc) begin
          pc_d         = target_s;
          addr_d       = target_s;
          buf_d        = NOP_INSTR;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = ST_FETCH;
        end else if (advance_s) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = buf_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc_s;
          addr_d       = pc_inc_s;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_KILL: begin
        if (PCSrc) begin
          pc_d         = target_s;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          // The stale response completing now frees the port for the target.
          if (imem_valid) begin
            addr_d  = target_s;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_KILL;
          end
        end else begin
          if (imem_valid) begin
            addr_d  = pc_q;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_KILL;
          end
          if (IF_IDwrite) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end else begin
            ifid_valid_d = ifid_valid_q;
          end
        end
      end

      default: begin
        state_d = ST_FETCH;
        addr_d  = pc_q;
      end
    endcase

    req_d = (state_d != ST_HOLD);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      buf_q        <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      buf_q        <= buf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Redirect cycles count as flushes only, never as stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PCSrc) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (!advance_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule
